// File: rtl/axis_to_pull_pkg.sv
// Shared defaults for the stream-to-pull adapter: widths and the almost-empty
// threshold derived from the address width.
package axis_to_pull_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    // Half of total capacity (RAM plus head register).
    function automatic int aempty_default(input int aw);
        return 1 << (aw - 1);
    endfunction

endpackage

// File: rtl/axis_to_pull_if.sv
// Bundles the producer-side AXI stream and the consumer-side pull strobe,
// data and status flags of the adapter.
interface axis_to_pull_if
    import axis_to_pull_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] idata;
    logic                  ivalid;
    logic                  iready;
    logic [DATA_WIDTH-1:0] odata;
    logic                  oenable;
    logic                  oaempty;
    logic                  underflow;

    modport master (
        output idata, ivalid, oenable,
        input  iready, odata, oaempty, underflow
    );

    modport slave (
        input  idata, ivalid, oenable,
        output iready, odata, oaempty, underflow
    );
endinterface

// File: rtl/simple_dual_port_ram_reg1.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// Neither the array nor the output register is reset.
module simple_dual_port_ram_reg1 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  wclock,
    input  logic                  wenable,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rclock,
    input  logic                  renable,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge wclock) begin
        if (wenable) mem[waddr] <= wdata;
    end

    always_ff @(posedge rclock) begin
        if (renable) rdata <= mem[raddr];
    end
endmodule

// File: rtl/axis_to_pull.sv
// AXI stream to pull-interface adapter: RAM FIFO plus a head register (the RAM
// output register), registered almost-empty flag and sticky underflow.
module axis_to_pull
    import axis_to_pull_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int AEMPTY_LIMIT = aempty_default(ADDR_WIDTH)
) (
    input logic           clock,
    input logic           resetn,
    axis_to_pull_if.slave bus
);
    localparam int LEVEL_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ADDR_WIDTH-1:0] size;
    logic [LEVEL_W-1:0]    level;
    logic                  hvalid_q, hvalid_d;
    logic                  running_q;
    logic                  oaempty_q, oaempty_d;
    logic                  underflow_q, underflow_d;
    logic                  iready;
    logic                  wenable;
    logic                  renable;
    logic [DATA_WIDTH-1:0] rdata;

    always_comb begin
        size        = waddr_q - raddr_q;
        // Ready depends on registers only, never on ivalid or oenable.
        iready      = running_q && !(&size);
        wenable     = bus.ivalid && iready;
        renable     = (|size) && (!hvalid_q || bus.oenable);
        waddr_d     = wenable ? waddr_q + ADDR_WIDTH'(1) : waddr_q;
        raddr_d     = renable ? raddr_q + ADDR_WIDTH'(1) : raddr_q;
        hvalid_d    = renable || (hvalid_q && !bus.oenable);
        level       = {1'b0, size} + LEVEL_W'(hvalid_q);
        oaempty_d   = (level < LEVEL_W'(AEMPTY_LIMIT));
        underflow_d = underflow_q || (bus.oenable && !hvalid_q);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            running_q   <= 1'b0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            hvalid_q    <= 1'b0;
            oaempty_q   <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            running_q   <= 1'b1;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            hvalid_q    <= hvalid_d;
            oaempty_q   <= oaempty_d;
            underflow_q <= underflow_d;
        end
    end

    // The RAM output register doubles as the head word presented to the consumer.
    simple_dual_port_ram_reg1 #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .wclock (clock),
        .wenable(wenable),
        .waddr  (waddr_q),
        .wdata  (bus.idata),
        .rclock (clock),
        .renable(renable),
        .raddr  (raddr_q),
        .rdata  (rdata)
    );

    assign bus.odata     = rdata;
    assign bus.iready    = iready;
    assign bus.oaempty   = oaempty_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_axis_to_pull.sv
// Randomized and directed bench for axis_to_pull against a queue-based model of
// stored words and the one-clock-lagged almost-empty flag.
module tb_axis_to_pull;
    import axis_to_pull_pkg::*;

    logic clock = 1'b0;
    logic resetn = 1'b1;

    axis_to_pull_if #(.DATA_WIDTH(8)) bus ();

    axis_to_pull #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (4),
        .AEMPTY_LIMIT(8)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] q[$];
    logic       exp_aempty = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One clock: drive at negedge, update the model, let the posedge happen.
    task automatic step(input logic v, input logic [7:0] d, input logic pull,
                        input logic gated, output logic xfer);
        logic do_pull;
        @(negedge clock);
        chk("oaempty", 32'(bus.oaempty), 32'(exp_aempty));
        do_pull     = pull && !(gated && bus.oaempty);
        bus.ivalid  = v;
        bus.idata   = d;
        bus.oenable = do_pull;
        xfer        = v && bus.iready;
        exp_aempty  = (q.size() < 8);
        if (do_pull && q.size() > 0) begin
            chk("odata", 32'(bus.odata), 32'(q[0]));
            void'(q.pop_front());
        end
        if (xfer) q.push_back(d);
        @(posedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn      = 1'b0;
        bus.ivalid  = 1'b0;
        bus.oenable = 1'b0;
        bus.idata   = '0;
        #1;
        chk("rst_underflow", 32'(bus.underflow), 0);
        chk("rst_oaempty", 32'(bus.oaempty), 1);
        chk("rst_iready", 32'(bus.iready), 0);
        q.delete();
        exp_aempty = 1'b1;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        #1 chk("iready_at_release", 32'(bus.iready), 0);
        @(posedge clock);
        #1 chk("iready_after_1st_edge", 32'(bus.iready), 1);
    endtask

    task automatic drain();
        logic x;
        int   guard = 0;
        step(0, 8'h00, 0, 0, x);
        step(0, 8'h00, 0, 0, x);
        while (q.size() > 0 && guard < 100) begin
            step(0, 8'h00, 1, 0, x);
            guard++;
        end
        step(0, 8'h00, 0, 0, x);
    endtask

    initial begin
        logic       x;
        logic [7:0] nd;
        int         xfers;
        int         pushed;
        int         guard;
        bit         reset_done;

        bus.ivalid  = 1'b0;
        bus.oenable = 1'b0;
        bus.idata   = '0;
        do_reset();

        // Ordering: three back-to-back words, pulls from two clocks after the first.
        step(1, 8'h11, 0, 0, x); chk("order_xfer0", 32'(x), 1);
        step(1, 8'h22, 0, 0, x); chk("order_xfer1", 32'(x), 1);
        step(1, 8'h33, 0, 0, x); chk("order_xfer2", 32'(x), 1);
        step(0, 8'h00, 1, 0, x);
        step(0, 8'h00, 1, 0, x);
        step(0, 8'h00, 1, 0, x);
        step(0, 8'h00, 0, 0, x);
        #1 chk("order_underflow", 32'(bus.underflow), 0);

        // Full: ivalid held, no pulls.
        xfers = 0;
        nd    = 8'h40;
        for (int i = 0; i < 20; i++) begin
            step(1, nd, 0, 0, x);
            if (x) begin xfers++; nd++; end
        end
        chk("full_count", 32'(xfers), 16);
        #1 chk("full_iready", 32'(bus.iready), 0);
        step(1, nd, 1, 0, x);
        chk("full_no_write_on_pull", 32'(x), 0);
        step(1, nd, 0, 0, x);
        chk("full_17th_accepted", 32'(x), 1);
        drain();

        // Almost-empty threshold at level 8.
        for (int i = 0; i < 8; i++) begin
            step(1, 8'h60 + 8'(i), 0, 0, x);
            chk("aempty_load", 32'(x), 1);
        end
        #1 chk("aempty_same_edge", 32'(bus.oaempty), 1);
        step(0, 8'h00, 0, 0, x);
        #1 chk("aempty_falls", 32'(bus.oaempty), 0);
        step(0, 8'h00, 1, 0, x);
        #1 chk("aempty_lag", 32'(bus.oaempty), 0);
        step(0, 8'h00, 0, 0, x);
        #1 chk("aempty_rises", 32'(bus.oaempty), 1);
        drain();

        // Underflow on an empty block, then a stream must still drain cleanly.
        #1 chk("uf_clear_before", 32'(bus.underflow), 0);
        step(0, 8'h00, 1, 0, x);
        #1 chk("uf_set", 32'(bus.underflow), 1);
        repeat (3) step(0, 8'h00, 0, 0, x);
        #1 chk("uf_sticky", 32'(bus.underflow), 1);
        pushed = 0;
        guard  = 0;
        while (pushed < 4 && guard < 50) begin
            step(1, 8'hA0 + 8'(pushed), 0, 0, x);
            if (x) pushed++;
            guard++;
        end
        chk("uf_stream_accepted", 32'(pushed), 4);
        drain();
        #1 chk("uf_still_set", 32'(bus.underflow), 1);

        // Bogus pull together with a write: flag sets, the word survives.
        do_reset();
        step(1, 8'h55, 1, 0, x);
        chk("uf_write_accepted", 32'(x), 1);
        #1 chk("uf_with_write", 32'(bus.underflow), 1);
        drain();

        // Soak with gated pulls and a mid-run reset holding five words.
        do_reset();
        pushed     = 0;
        guard      = 0;
        reset_done = 0;
        while (pushed < 1000 && guard < 30000) begin
            if (!reset_done && pushed >= 500) begin
                step(0, 8'h00, 0, 0, x);
                step(0, 8'h00, 0, 0, x);
                while (q.size() > 5) step(0, 8'h00, 1, 0, x);
                while (q.size() < 5) begin
                    step(1, 8'($urandom), 0, 0, x);
                    if (x) pushed++;
                end
                do_reset();
                reset_done = 1;
            end
            step(($urandom_range(0, 99) < 70), 8'($urandom), 1'($urandom_range(0, 1)), 1, x);
            if (x) pushed++;
            guard++;
        end
        chk("soak_words", 32'(pushed), 1000);
        chk("soak_reset_done", 32'(reset_done), 1);
        drain();
        #1 chk("soak_underflow", 32'(bus.underflow), 0);
        chk("soak_final_aempty", 32'(bus.oaempty), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
